// File: rtl/ub_ctrl_pkg.sv
// Shared types, size encodings and default widths for the unified-buffer fetch path.
package ub_ctrl_pkg;

  localparam int unsigned DEF_SA_ROWS = 16;
  localparam int unsigned DEF_WADDR_W = 12;
  localparam int unsigned DEF_IADDR_W = 10;
  localparam int unsigned DEF_ILEN_W  = 11;

  localparam logic [1:0] UB_SIZE_ILLEGAL = 2'b00;
  localparam logic [1:0] UB_SIZE_128     = 2'b01;
  localparam logic [1:0] UB_SIZE_256     = 2'b10;
  localparam logic [1:0] UB_SIZE_512     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_W   = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_STREAM_I = 3'd3,
    ST_DONE     = 3'd4
  } fetch_state_t;

  // Weight address increment per beat for a given array-size encoding.
  function automatic logic [2:0] w_step(input logic [1:0] size);
    case (size)
      UB_SIZE_256: w_step = 3'd2;
      UB_SIZE_512: w_step = 3'd4;
      default:     w_step = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/ub_fetch_sequencer_if.sv
// Command, UB read-port and systolic-array handshake bundle for ub_fetch_sequencer.
// master: sequencer side (consumes command/abort/sa_ready, drives UB reads and status).
// slave:  control-unit / UB / array side.
interface ub_fetch_sequencer_if #(
  parameter int unsigned WADDR_W = ub_ctrl_pkg::DEF_WADDR_W,
  parameter int unsigned IADDR_W = ub_ctrl_pkg::DEF_IADDR_W,
  parameter int unsigned ILEN_W  = ub_ctrl_pkg::DEF_ILEN_W
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [WADDR_W-1:0] cmd_w_base;
  logic [1:0]         cmd_w_size;
  logic [IADDR_W-1:0] cmd_i_base;
  logic [ILEN_W-1:0]  cmd_i_rows;
  logic               abort;
  logic               sa_ready;
  logic               ub_rd_weight_en;
  logic [WADDR_W-1:0] ub_rd_weight_addr;
  logic [1:0]         ub_rd_weight_size;
  logic               ub_rd_input_en;
  logic [IADDR_W-1:0] ub_rd_input_addr;
  logic               sa_weight_commit;
  logic               busy;
  logic               done;
  logic               cmd_err;

  modport master (
    input  cmd_valid, cmd_w_base, cmd_w_size, cmd_i_base, cmd_i_rows, abort, sa_ready,
    output cmd_ready, ub_rd_weight_en, ub_rd_weight_addr, ub_rd_weight_size,
           ub_rd_input_en, ub_rd_input_addr, sa_weight_commit, busy, done, cmd_err
  );

  modport slave (
    output cmd_valid, cmd_w_base, cmd_w_size, cmd_i_base, cmd_i_rows, abort, sa_ready,
    input  cmd_ready, ub_rd_weight_en, ub_rd_weight_addr, ub_rd_weight_size,
           ub_rd_input_en, ub_rd_input_addr, sa_weight_commit, busy, done, cmd_err
  );
endinterface

// File: rtl/ub_addr_walker.sv
// Loadable address pointer plus beat counter.
//  load    : addr <= base, count <= 0
//  advance : addr <= addr + step (wraps), count <= count + 1
//  last_c  : the current beat is the target-th one (count == target-1)
module ub_addr_walker #(
  parameter int unsigned AW = 12,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] step,
  input  logic [CW-1:0] target,
  output logic [AW-1:0] addr,
  output logic          last_c
);
  logic [CW-1:0] count;

  // Pointer and count; load wins over advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= base;
      count <= '0;
    end else if (advance) begin
      addr  <= addr + step;
      count <= count + CW'(1);
    end
  end

  assign last_c = (count == target - CW'(1));
endmodule

// File: rtl/ub_fetch_sequencer.sv
// Tile read sequencer: loads SA_ROWS weight rows from the UB, pulses a weight
// commit to the systolic array, then streams the tile's input rows.
// Ports: clk, rst (sync, active-high); bus (ub_fetch_sequencer_if.master) carrying
// the tile command, abort, sa_ready, UB weight/input read ports and status pulses.
module ub_fetch_sequencer
  import ub_ctrl_pkg::*;
#(
  parameter int unsigned SA_ROWS = DEF_SA_ROWS,
  parameter int unsigned WADDR_W = DEF_WADDR_W,
  parameter int unsigned IADDR_W = DEF_IADDR_W,
  parameter int unsigned ILEN_W  = DEF_ILEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  ub_fetch_sequencer_if.master bus
);
  localparam int unsigned WCNT_W = $clog2(SA_ROWS + 1);

  fetch_state_t      state, state_next;
  logic              accept_c, w_adv_c, i_adv_c, w_last_c, i_last_c;
  logic [1:0]        w_size_q;
  logic [ILEN_W-1:0] i_rows_q;
  logic              commit_q, done_q, err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and beat strobes; abort outranks beat completion.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    w_adv_c    = 1'b0;
    i_adv_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid && (bus.cmd_w_size != UB_SIZE_ILLEGAL)) begin
          accept_c   = 1'b1;
          state_next = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (bus.abort) begin
          state_next = ST_IDLE;
        end else if (bus.sa_ready) begin
          w_adv_c = 1'b1;
          if (w_last_c) state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (bus.abort)               state_next = ST_IDLE;
        else if (i_rows_q != '0)     state_next = ST_STREAM_I;
        else                         state_next = ST_DONE;
      end
      ST_STREAM_I: begin
        if (bus.abort) begin
          state_next = ST_IDLE;
        end else if (bus.sa_ready) begin
          i_adv_c = 1'b1;
          if (i_last_c) state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Latched command fields and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_size_q <= '0;
      i_rows_q <= '0;
      commit_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept_c) begin
        w_size_q <= bus.cmd_w_size;
        i_rows_q <= bus.cmd_i_rows;
      end
      // Pulses line up with the one-cycle COMMIT/DONE states.
      commit_q <= (state_next == ST_COMMIT);
      done_q   <= (state_next == ST_DONE);
      err_q    <= (state == ST_IDLE) && bus.cmd_valid && (bus.cmd_w_size == UB_SIZE_ILLEGAL);
    end
  end

  ub_addr_walker #(.AW(WADDR_W), .CW(WCNT_W)) u_w_walker (
    .clk     (clk),
    .rst     (rst),
    .load    (accept_c),
    .advance (w_adv_c),
    .base    (bus.cmd_w_base),
    .step    (WADDR_W'(w_step(w_size_q))),
    .target  (WCNT_W'(SA_ROWS)),
    .addr    (bus.ub_rd_weight_addr),
    .last_c  (w_last_c)
  );

  ub_addr_walker #(.AW(IADDR_W), .CW(ILEN_W)) u_i_walker (
    .clk     (clk),
    .rst     (rst),
    .load    (accept_c),
    .advance (i_adv_c),
    .base    (bus.cmd_i_base),
    .step    (IADDR_W'(1)),
    .target  (i_rows_q),
    .addr    (bus.ub_rd_input_addr),
    .last_c  (i_last_c)
  );

  assign bus.cmd_ready         = (state == ST_IDLE);
  assign bus.busy              = (state != ST_IDLE);
  assign bus.ub_rd_weight_en   = (state == ST_LOAD_W);
  assign bus.ub_rd_input_en    = (state == ST_STREAM_I);
  assign bus.ub_rd_weight_size = w_size_q;
  assign bus.sa_weight_commit  = commit_q;
  assign bus.done              = done_q;
  assign bus.cmd_err           = err_q;
endmodule

// File: tb/tb_ub_fetch_sequencer.sv
// Self-checking bench for ub_fetch_sequencer. Each command's expected per-cycle
// behaviour is laid out up front as a trace from the tile rules (weight beats,
// commit, input beats, done, with chosen stall cycles), then replayed and compared.
module tb_ub_fetch_sequencer;
  import ub_ctrl_pkg::*;

  localparam int SA = int'(DEF_SA_ROWS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ub_fetch_sequencer_if bus ();
  ub_fetch_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;
  bit [1:0] cur_size = 2'b00;

  typedef struct {
    bit        sa;
    bit        ab;
    bit        noise;
    bit        w_en;
    bit [11:0] w_addr;
    bit        i_en;
    bit [9:0]  i_addr;
    bit        commit;
    bit        done;
    bit        busy;
  } cyc_t;

  cyc_t trace[$];

  function automatic cyc_t mk(bit sa, bit ab, bit w_en, bit [11:0] wa, bit i_en, bit [9:0] ia,
                              bit cm, bit dn, bit busy, bit noise);
    cyc_t c;
    c.sa = sa; c.ab = ab; c.w_en = w_en; c.w_addr = wa; c.i_en = i_en; c.i_addr = ia;
    c.commit = cm; c.done = dn; c.busy = busy; c.noise = noise;
    return c;
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid  = 1'b0;
    bus.abort      = 1'b0;
    bus.sa_ready   = 1'b0;
    bus.cmd_w_base = '0;
    bus.cmd_w_size = '0;
    bus.cmd_i_base = '0;
    bus.cmd_i_rows = '0;
  endtask

  // Issue one command on the current cycle, then replay its expected trace.
  task automatic run_cmd(input string name, input bit [11:0] wbase, input bit [1:0] size,
                         input bit [9:0] ibase, input int rows, input int max_stall,
                         input int stall_i_beat, input int stall_len, input int abort_w_beat,
                         input bit noise, output int lat, output int stalls);
    int step;
    bit aborted;
    logic [8:0] obs, exp;
    step    = (size == 2'b11) ? 4 : (size == 2'b10) ? 2 : 1;
    stalls  = 0;
    aborted = 1'b0;
    lat     = -1;
    trace.delete();
    for (int k = 0; k < SA; k++) begin
      bit [11:0] wa;
      int s;
      wa = 12'((int'(wbase) + k * step) % 4096);
      s  = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      stalls += s;
      for (int j = 0; j < s; j++) trace.push_back(mk(0, 0, 1, wa, 0, 0, 0, 0, 1, noise));
      trace.push_back(mk(1, k == abort_w_beat, 1, wa, 0, 0, 0, 0, 1, noise));
      if (k == abort_w_beat) begin
        trace.push_back(mk(1'($urandom), 0, 0, 0, 0, 0, 0, 0, 0, 0));
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      trace.push_back(mk(1'($urandom), 0, 0, 0, 0, 0, 1, 0, 1, noise));
      for (int k = 0; k < rows; k++) begin
        bit [9:0] ia;
        int s;
        ia = 10'((int'(ibase) + k) % 1024);
        s  = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        if (k == stall_i_beat) s += stall_len;
        stalls += s;
        for (int j = 0; j < s; j++) trace.push_back(mk(0, 0, 0, 0, 1, ia, 0, 0, 1, noise));
        trace.push_back(mk(1, 0, 0, 0, 1, ia, 0, 0, 1, noise));
      end
      trace.push_back(mk(1'($urandom), 0, 0, 0, 0, 0, 0, 1, 1, noise));
    end

    // Acceptance cycle: abort here must be ignored since the sequencer is idle.
    bus.cmd_valid  = 1'b1;
    bus.cmd_w_base = wbase;
    bus.cmd_w_size = size;
    bus.cmd_i_base = ibase;
    bus.cmd_i_rows = 11'(rows);
    bus.sa_ready   = 1'($urandom);
    bus.abort      = noise & 1'($urandom);
    @(negedge clk);
    n_total++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.sa_weight_commit, bus.ub_rd_weight_en,
         bus.ub_rd_input_en} !== 6'b100000)
      $display("FAIL %s accept: ready/busy/done/commit/wen/ien got %b want 100000", name,
               {bus.cmd_ready, bus.busy, bus.done, bus.sa_weight_commit, bus.ub_rd_weight_en,
                bus.ub_rd_input_en});
    else n_pass++;
    @(posedge clk); #1;
    cur_size = size;

    foreach (trace[i]) begin
      bus.sa_ready  = trace[i].sa;
      bus.abort     = trace[i].ab;
      bus.cmd_valid = trace[i].noise & 1'($urandom);
      if (trace[i].noise) begin
        bus.cmd_w_base = 12'($urandom);
        bus.cmd_w_size = 2'($urandom);
        bus.cmd_i_base = 10'($urandom);
        bus.cmd_i_rows = 11'($urandom);
      end
      @(negedge clk);
      obs = {bus.ub_rd_weight_en, bus.ub_rd_input_en, bus.sa_weight_commit, bus.done, bus.busy,
             bus.cmd_ready, bus.cmd_err, bus.ub_rd_weight_size};
      exp = {trace[i].w_en, trace[i].i_en, trace[i].commit, trace[i].done, trace[i].busy,
             !trace[i].busy, 1'b0, cur_size};
      n_total++;
      if (obs !== exp)
        $display("FAIL %s cyc%0d wen/ien/commit/done/busy/ready/err/size got %b want %b",
                 name, i + 1, obs, exp);
      else n_pass++;
      if (trace[i].w_en) begin
        n_total++;
        if (bus.ub_rd_weight_addr !== trace[i].w_addr)
          $display("FAIL %s cyc%0d weight_addr got %h want %h", name, i + 1,
                   bus.ub_rd_weight_addr, trace[i].w_addr);
        else n_pass++;
      end
      if (trace[i].i_en) begin
        n_total++;
        if (bus.ub_rd_input_addr !== trace[i].i_addr)
          $display("FAIL %s cyc%0d input_addr got %h want %h", name, i + 1,
                   bus.ub_rd_input_addr, trace[i].i_addr);
        else n_pass++;
      end
      if (bus.done === 1'b1 && lat < 0) lat = i + 1;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [30:0] obs;
    rst = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_w_size = UB_SIZE_128;
    bus.cmd_w_base = 12'($urandom);
    bus.cmd_i_base = 10'($urandom);
    bus.cmd_i_rows = 11'd5;
    bus.sa_ready   = 1'b1;
    bus.abort      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {bus.cmd_ready, bus.busy, bus.ub_rd_weight_en, bus.ub_rd_input_en, bus.sa_weight_commit,
           bus.done, bus.cmd_err, bus.ub_rd_weight_size, bus.ub_rd_weight_addr, bus.ub_rd_input_addr};
    n_total++;
    if (obs !== {1'b1, 30'd0}) $display("FAIL reset_state got %h want %h", obs, {1'b1, 30'd0});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_total++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10)
      $display("FAIL post_reset_idle ready/busy got %b want 10", {bus.cmd_ready, bus.busy});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, st;
    run_cmd("basic", 12'h010, UB_SIZE_128, 10'h020, 4, 0, -1, 0, -1, 0, lat, st);
    n_total++;
    if (lat !== SA + 1 + 4 + 1) $display("FAIL basic_latency got %0d want %0d", lat, SA + 6);
    else n_pass++;
  endtask

  task automatic test_weight_wrap();
    int lat, st;
    run_cmd("wwrap", 12'hFF8, UB_SIZE_512, 10'h100, 3, 0, -1, 0, -1, 0, lat, st);
    n_total++;
    if (lat !== SA + 1 + 3 + 1) $display("FAIL wwrap_latency got %0d want %0d", lat, SA + 5);
    else n_pass++;
  endtask

  task automatic test_input_wrap();
    int lat, st;
    run_cmd("iwrap", 12'h200, UB_SIZE_256, 10'h3FE, 4, 0, -1, 0, -1, 0, lat, st);
    n_total++;
    if (lat !== SA + 1 + 4 + 1) $display("FAIL iwrap_latency got %0d want %0d", lat, SA + 6);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat, st;
    run_cmd("bp", 12'h010, UB_SIZE_128, 10'h020, 4, 0, 2, 3, -1, 0, lat, st);
    n_total++;
    if (lat !== SA + 1 + 4 + 1 + 3) $display("FAIL bp_latency got %0d want %0d", lat, SA + 9);
    else n_pass++;
  endtask

  task automatic test_zero_rows();
    int lat, st;
    run_cmd("zero_rows", 12'h0A0, UB_SIZE_256, 10'h055, 0, 0, -1, 0, -1, 0, lat, st);
    n_total++;
    if (lat !== SA + 2) $display("FAIL zero_rows_latency got %0d want %0d", lat, SA + 2);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [6:0] obs;
    bus.cmd_valid  = 1'b1;
    bus.cmd_w_size = UB_SIZE_ILLEGAL;
    bus.cmd_w_base = 12'h123;
    bus.cmd_i_base = 10'h045;
    bus.cmd_i_rows = 11'd3;
    bus.sa_ready   = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    bus.sa_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      obs = {bus.cmd_err, bus.cmd_ready, bus.busy, bus.ub_rd_weight_en, bus.ub_rd_input_en,
             bus.ub_rd_weight_size};
      n_total++;
      if (obs !== {c == 0, 1'b1, 1'b0, 1'b0, 1'b0, cur_size})
        $display("FAIL illegal cyc%0d err/ready/busy/wen/ien/size got %b want %b", c, obs,
                 {c == 0, 1'b1, 1'b0, 1'b0, 1'b0, cur_size});
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    int lat, st;
    run_cmd("abort", 12'h300, UB_SIZE_128, 10'h010, 6, 0, -1, 0, 4, 0, lat, st);
    n_total++;
    if (lat !== -1) $display("FAIL abort_no_done got %0d want -1", lat);
    else n_pass++;
    run_cmd("after_abort", 12'h040, UB_SIZE_256, 10'h0C0, 2, 0, -1, 0, -1, 0, lat, st);
    n_total++;
    if (lat !== SA + 1 + 2 + 1) $display("FAIL after_abort_latency got %0d want %0d", lat, SA + 4);
    else n_pass++;
  endtask

  task automatic test_back_to_back_random();
    int lat, st, rows;
    bit [1:0] sz;
    for (int n = 0; n < 10; n++) begin
      rows = int'($urandom_range(24, 0));
      sz   = 2'($urandom_range(3, 1));
      run_cmd("rand", 12'($urandom), sz, 10'($urandom), rows, 2, -1, 0, -1, 1, lat, st);
      n_total++;
      if (lat !== SA + 2 + rows + st)
        $display("FAIL rand%0d_latency got %0d want %0d", n, lat, SA + 2 + rows + st);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_weight_wrap();
    test_input_wrap();
    test_backpressure();
    test_zero_rows();
    test_illegal();
    test_abort();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
